divisor_secuencial: RTL and testbench

Sequential restoring divider: the inverse operation of the shift-add multiplier, using the same Start/Ready handshake.
- Divides a 2N-bit dividend by an N-bit divisor, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath; intended to check and undo products (dividend = product, divisor = one factor).

---
 rtl/divisor_pkg.sv | 19 +
 rtl/divisor_secuencial_if.sv | 26 ++
 rtl/divisor_secuencial_paso_resta.sv | 21 ++
 rtl/divisor_secuencial.sv | 102 ++++++++++
 tb/tb_divisor_secuencial.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/divisor_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and iteration-counter sizing.
package divisor_pkg;

    localparam int N_DEF = 8;
    localparam int CNT_W = $clog2(2 * N_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter must reach 2N, hence the +1.
    function automatic int cnt_width(input int n);
        return $clog2(2 * n + 1);
    endfunction

endpackage

// File: rtl/divisor_secuencial_if.sv
// Start/Ready request bus of the divider: operands in, quotient/remainder and
// status flags out.
interface divisor_secuencial_if
    import divisor_pkg::*;
#(
    parameter int N = N_DEF
);
    logic               start;
    logic [2*N-1:0]     dividendo;
    logic [N-1:0]       divisor;
    logic [2*N-1:0]     cociente;
    logic [N-1:0]       residuo;
    logic               ready;
    logic               busy;
    logic               div_cero;

    modport master (
        output start, dividendo, divisor,
        input  cociente, residuo, ready, busy, div_cero
    );

    modport slave (
        input  start, dividendo, divisor,
        output cociente, residuo, ready, busy, div_cero
    );
endinterface

// File: rtl/divisor_secuencial_paso_resta.sv
// One restoring-division step: shift in the next dividend bit and subtract
// the divisor when it fits.
module paso_resta #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_r,
    input  logic         i_bit,
    input  logic [N-1:0] i_divisor,
    output logic [N-1:0] o_r,
    output logic         o_q
);
    logic [N:0]   w_shift;
    logic [N-1:0] w_diff;

    assign w_shift = {i_r, i_bit};
    assign o_q     = (w_shift >= {1'b0, i_divisor});
    // When the subtraction is taken the result is below the divisor, so the
    // modulo-2^N difference is exact.
    assign w_diff  = w_shift[N-1:0] - i_divisor;
    assign o_r     = o_q ? w_diff : w_shift[N-1:0];
endmodule

// File: rtl/divisor_secuencial.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one quotient
// bit per clock, Start/Ready handshake.
module divisor_secuencial
    import divisor_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    divisor_secuencial_if.slave  bus
);
    localparam int             CW      = cnt_width(N);
    localparam logic [CW-1:0]  CNT_END = CW'(2 * N);

    state_t          r_state, w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [2*N-1:0]  r_dividend;
    logic [2*N-1:0]  r_quot;
    logic [2*N-1:0]  r_cociente;
    logic [N-1:0]    r_divisor;
    logic [N-1:0]    r_rem;
    logic [N-1:0]    r_residuo;
    logic            r_ready;
    logic            r_div_cero;
    logic            r_zero_pend;
    logic            w_accept;
    logic            w_last;
    logic            w_q;
    logic [N-1:0]    w_rem_next;

    paso_resta #(.N(N)) u_paso (
        .i_r       (r_rem),
        .i_bit     (r_dividend[2*N-1]),
        .i_divisor (r_divisor),
        .o_r       (w_rem_next),
        .o_q       (w_q)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = bus.start && (r_state != RUN);
        w_last       = (r_cnt == CNT_END);
        case (r_state)
            IDLE, DONE: if (w_accept) w_state_next = (bus.divisor == '0) ? DONE : RUN;
            RUN:        if (w_last)   w_state_next = DONE;
            default:    w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
            r_cociente  <= '0;
            r_residuo   <= '0;
            r_ready     <= 1'b0;
            r_div_cero  <= 1'b0;
            r_zero_pend <= 1'b0;
        end else if (w_accept) begin
            r_cnt       <= '0;
            r_dividend  <= bus.dividendo;
            r_divisor   <= bus.divisor;
            r_rem       <= '0;
            r_quot      <= '0;
            r_ready     <= 1'b0;
            r_div_cero  <= 1'b0;
            r_zero_pend <= (bus.divisor == '0);
        end else if (r_state == RUN) begin
            if (w_last) begin
                r_cociente <= r_quot;
                r_residuo  <= r_rem;
                r_ready    <= 1'b1;
            end else begin
                r_rem      <= w_rem_next;
                r_quot     <= {r_quot[2*N-2:0], w_q};
                r_dividend <= {r_dividend[2*N-2:0], 1'b0};
                r_cnt      <= r_cnt + 1'b1;
            end
        end else if (r_zero_pend) begin
            // Divide-by-zero result appears one edge after the accept.
            r_cociente  <= '1;
            r_residuo   <= r_dividend[N-1:0];
            r_ready     <= 1'b1;
            r_div_cero  <= 1'b1;
            r_zero_pend <= 1'b0;
        end
    end

    assign bus.cociente = r_cociente;
    assign bus.residuo  = r_residuo;
    assign bus.ready    = r_ready;
    assign bus.busy     = (r_state == RUN);
    assign bus.div_cero = r_div_cero;
endmodule

// File: tb/tb_divisor_secuencial.sv
// Self-checking bench for divisor_secuencial: directed cases, handshake corner
// cases and randomized operands against an arithmetic reference model.
module tb_divisor_secuencial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    divisor_secuencial_if #(.N(8)) bus ();

    divisor_secuencial #(.N(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: result is plain integer division, visible 17 edges
    // after the accept (1 edge for a zero divisor).
    logic [15:0] m_q = '0, p_q = '0, m_dd = '0;
    logic [7:0]  m_r = '0, p_r = '0, m_dv = '0;
    logic        m_ready = 1'b0, m_busy = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
    int          m_cd = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q = '0; m_r = '0; m_ready = 1'b0; m_busy = 1'b0; m_dz = 1'b0; m_cd = 0;
        end else if (bus.start && !m_busy) begin
            m_ready = 1'b0;
            m_dz    = 1'b0;
            m_dd    = bus.dividendo;
            m_dv    = bus.divisor;
            if (m_dv == 8'd0) begin
                p_q = 16'hFFFF; p_r = m_dd[7:0]; p_dz = 1'b1; m_cd = 1;
            end else begin
                p_q = m_dd / m_dv; p_r = 8'(m_dd % m_dv); p_dz = 1'b0; m_cd = 17; m_busy = 1'b1;
            end
        end else if (m_cd > 0) begin
            m_cd = m_cd - 1;
            if (m_cd == 0) begin
                m_ready = 1'b1; m_busy = 1'b0; m_q = p_q; m_r = p_r; m_dz = p_dz;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("cycle", {5'd0, bus.cociente, bus.residuo, bus.ready, bus.busy, bus.div_cero},
                     {5'd0, m_q, m_r, m_ready, m_busy, m_dz});
        if (bus.ready && !bus.div_cero)
            chk("invariant", 32'(bus.cociente) * 32'(m_dv) + 32'(bus.residuo), 32'(m_dd));
    end

    // Counts edges after the accept edge until Ready is seen (bounded).
    task automatic wait_ready(inout int lat);
        while (!bus.ready && lat < 40) begin
            @(posedge clk); #2;
            lat++;
        end
        if (lat >= 40) chk("ready_timeout", 32'(lat), 32'd17);
    endtask

    task automatic run_op(input logic [15:0] dd, input logic [7:0] dv);
        int lat = 0;
        bus.dividendo = dd; bus.divisor = dv; bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        bus.dividendo = 16'($urandom); bus.divisor = 8'($urandom);
        wait_ready(lat);
        chk("latency", 32'(lat), (dv == 0) ? 32'd1 : 32'd17);
        chk("div_cero", 32'(bus.div_cero), (dv == 0) ? 32'd1 : 32'd0);
        chk("cociente", 32'(bus.cociente), (dv == 0) ? 32'hFFFF : 32'(dd / dv));
        chk("residuo", 32'(bus.residuo), (dv == 0) ? 32'(dd[7:0]) : 32'(dd % dv));
        $display("op %0d / %0d -> q=%0d r=%0d dz=%0d lat=%0d",
                 dd, dv, bus.cociente, bus.residuo, bus.div_cero, lat);
    endtask

    initial begin
        int lat;
        int rc;
        logic prev_ready;
        logic [15:0] dd;
        logic [7:0]  dv;
        bus.start = 1'b0; bus.dividendo = '0; bus.divisor = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        chk("reset_outputs", {5'd0, bus.cociente, bus.residuo, bus.ready, bus.busy, bus.div_cero}, 32'd0);

        run_op(16'd47945, 8'd215);
        chk("pin_47945_q", 32'(bus.cociente), 32'd223);
        chk("pin_47945_r", 32'(bus.residuo), 32'd0);
        run_op(16'd16922, 8'd85);
        chk("pin_16922_q", 32'(bus.cociente), 32'd199);
        chk("pin_16922_r", 32'(bus.residuo), 32'd7);
        run_op(16'd100, 8'd200);
        chk("pin_100_r", 32'(bus.residuo), 32'd100);
        run_op(16'd65535, 8'd1);
        chk("pin_65535_q", 32'(bus.cociente), 32'd65535);
        run_op(16'd1234, 8'd0);
        chk("pin_div0_r", 32'(bus.residuo), 32'hD2);

        // Start re-pulsed during iteration 5 must be ignored.
        bus.dividendo = 16'd47945; bus.divisor = 8'd215; bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        bus.dividendo = 16'd1000; bus.divisor = 8'd3; bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        lat = 5;
        wait_ready(lat);
        chk("repulse_latency", 32'(lat), 32'd17);
        chk("repulse_q", 32'(bus.cociente), 32'd223);
        chk("repulse_r", 32'(bus.residuo), 32'd0);
        $display("op repulse ignored -> q=%0d r=%0d lat=%0d", bus.cociente, bus.residuo, lat);

        // Asynchronous reset between edges in the middle of a division.
        bus.dividendo = 16'd16922; bus.divisor = 8'd85; bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("async_reset", {5'd0, bus.cociente, bus.residuo, bus.ready, bus.busy, bus.div_cero}, 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #2;
        run_op(16'd47945, 8'd215);
        chk("post_reset_q", 32'(bus.cociente), 32'd223);

        // Start held high: back-to-back 255/16 with a one-cycle Ready.
        bus.dividendo = 16'd255; bus.divisor = 8'd16; bus.start = 1'b1;
        rc = 0; prev_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            if (bus.ready) begin
                rc++;
                chk("held_q", 32'(bus.cociente), 32'd15);
                chk("held_r", 32'(bus.residuo), 32'd15);
                chk("held_ready_single", 32'(prev_ready), 32'd0);
            end
            prev_ready = bus.ready;
        end
        bus.start = 1'b0;
        chk("held_ready_count", 32'(rc), 32'd2);
        $display("op held start 255 / 16 -> ready pulses=%0d", rc);
        for (int i = 0; i < 40 && bus.busy; i++) begin
            @(posedge clk); #2;
        end

        // Randomized operands, some exact products, some zero divisors.
        for (int i = 0; i < 150; i++) begin
            dv = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            dd = 16'($urandom);
            if ($urandom_range(0, 2) == 0) dd = 16'(8'($urandom) * dv);
            run_op(dd, dv);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
